// File: rtl/player_mover.sv
// Per-tick head movement for one TRON player: checks the next cell against the arena walls
// and the trail memory, then either commits the step or declares a crash.
module player_mover #(
  parameter int unsigned GRID_W   = 160,
  parameter int unsigned GRID_H   = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned START_X  = 40,
  parameter int unsigned START_Y  = 60
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  input  logic [1:0]     direction_in,
  output logic           occ_query_valid,
  output logic [X_W-1:0] occ_query_x,
  output logic [Y_W-1:0] occ_query_y,
  input  logic           occ_valid,
  input  logic           occ_hit,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           trail_we,
  output logic           step,
  output logic           crashed,
  output logic           running
);

  localparam int unsigned     CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
  localparam logic [X_W-1:0]  XMax     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]  YMax     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]  SpawnX   = X_W'(START_X);
  localparam logic [Y_W-1:0]  SpawnY   = Y_W'(START_Y);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StQuery,
    StMove,
    StCrashed
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] tick_q;
  logic [1:0]      dir_q;
  logic [X_W-1:0]  pos_x_q, qry_x_q;
  logic [Y_W-1:0]  pos_y_q, qry_y_q;
  logic            qry_valid_q, spawn_we_q, crashed_q, running_q;

  logic            tick_done, wall;
  logic [1:0]      dir_sel;
  logic [X_W-1:0]  nx;
  logic [Y_W-1:0]  ny;

  // Walls are tested on the current cell before any arithmetic, so coordinates never wrap.
  always_comb begin
    tick_done = (state_q == StWaitTick) && (tick_q == TickLast);
    dir_sel   = tick_done ? direction_in : dir_q;
    nx        = pos_x_q;
    ny        = pos_y_q;
    wall      = 1'b0;
    unique case (dir_sel)
      2'b00: begin wall = (pos_y_q == '0);   ny = pos_y_q - Y_W'(1); end
      2'b01: begin wall = (pos_x_q == XMax); nx = pos_x_q + X_W'(1); end
      2'b10: begin wall = (pos_y_q == YMax); ny = pos_y_q + Y_W'(1); end
      2'b11: begin wall = (pos_x_q == '0);   nx = pos_x_q - X_W'(1); end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      dir_q       <= 2'b01;
      pos_x_q     <= SpawnX;
      pos_y_q     <= SpawnY;
      qry_x_q     <= '0;
      qry_y_q     <= '0;
      qry_valid_q <= 1'b0;
      spawn_we_q  <= 1'b0;
      crashed_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      spawn_we_q <= 1'b0;
      case (state_q)
        StIdle, StCrashed: begin
          if (start) begin
            state_q    <= StWaitTick;
            tick_q     <= '0;
            pos_x_q    <= SpawnX;
            pos_y_q    <= SpawnY;
            spawn_we_q <= 1'b1;
            crashed_q  <= 1'b0;
            running_q  <= 1'b1;
          end
        end
        StWaitTick: begin
          if (tick_done) begin
            dir_q  <= direction_in;
            tick_q <= '0;
            if (wall) begin
              state_q   <= StCrashed;
              crashed_q <= 1'b1;
              running_q <= 1'b0;
            end else begin
              state_q     <= StQuery;
              qry_x_q     <= nx;
              qry_y_q     <= ny;
              qry_valid_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + CntW'(1);
          end
        end
        StQuery: begin
          if (occ_valid) begin
            qry_valid_q <= 1'b0;
            if (occ_hit) begin
              state_q   <= StCrashed;
              crashed_q <= 1'b1;
              running_q <= 1'b0;
            end else begin
              // Head moves on entry to MOVE so the trail write addresses the new cell.
              state_q <= StMove;
              pos_x_q <= qry_x_q;
              pos_y_q <= qry_y_q;
            end
          end
        end
        StMove: begin
          state_q <= StWaitTick;
          tick_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign occ_query_valid = qry_valid_q;
  assign occ_query_x     = qry_x_q;
  assign occ_query_y     = qry_y_q;
  assign pos_x           = pos_x_q;
  assign pos_y           = pos_y_q;
  assign step            = (state_q == StMove);
  assign trail_we        = spawn_we_q | (state_q == StMove);
  assign crashed         = crashed_q;
  assign running         = running_q;

endmodule

// File: tb/tb_player_mover.sv
// Randomised scoreboard bench for player_mover: a grid-level model predicts spawn, query,
// move and crash events with their cycle numbers; a negedge monitor matches what appears.
module tb_player_mover;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int TD = 4;
  localparam int SX = 2;
  localparam int SY = 2;

  localparam int EvSpawn = 0;
  localparam int EvQuery = 1;
  localparam int EvMove  = 2;
  localparam int EvCrash = 3;

  typedef struct {
    int kind;
    int x;
    int y;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn, start, occ_valid, occ_hit;
  logic [1:0] direction_in;
  logic       occ_query_valid, trail_we, step, crashed, running;
  logic [7:0] occ_query_x, pos_x;
  logic [6:0] occ_query_y, pos_y;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_en  = 1'b1;

  // Model state owned by the stimulus process
  int  px, py, ts, n_steps;
  bit  occ[GW][GH];

  player_mover #(
    .GRID_W(GW), .GRID_H(GH), .X_W(8), .Y_W(7), .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
  ) dut (
    .CLOCK_50       (clk),
    .resetn         (resetn),
    .start          (start),
    .direction_in   (direction_in),
    .occ_query_valid(occ_query_valid),
    .occ_query_x    (occ_query_x),
    .occ_query_y    (occ_query_y),
    .occ_valid      (occ_valid),
    .occ_hit        (occ_hit),
    .pos_x          (pos_x),
    .pos_y          (pos_y),
    .trail_we       (trail_we),
    .step           (step),
    .crashed        (crashed),
    .running        (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EvSpawn: return "spawn";
      EvQuery: return "query";
      EvMove:  return "move";
      default: return "crash";
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push(input int kind, input int x, input int y, input int c);
    ev_t e;
    e.kind = kind; e.x = x; e.y = y; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int x, input int y, output int ex, output int ey);
    ev_t e;
    n_tests++;
    ex = -1;
    ey = -1;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_%s: got (%0d,%0d) at cycle %0d, expected no event",
               kname(kind), x, y, cyc);
    end else begin
      e  = exp_q.pop_front();
      ex = e.x;
      ey = e.y;
      if (e.kind != kind || e.x != x || e.y != y || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event_%s: got %s (%0d,%0d) at cycle %0d, expected %s (%0d,%0d) at cycle %0d",
                 kname(kind), kname(kind), x, y, cyc, kname(e.kind), e.x, e.y, e.cyc);
      end
    end
  endtask

  // Monitor
  bit qv_prev, cr_prev;
  int qx_exp, qy_exp, fx, fy, ex, ey;
  always @(negedge clk) begin
    if (!resetn || !mon_en) begin
      qv_prev = 1'b0;
      cr_prev = 1'b0;
    end else begin
      if (step) check("step_implies_trail_we", trail_we, 1);
      if (trail_we) observe(step ? EvMove : EvSpawn, pos_x, pos_y, ex, ey);
      if (occ_query_valid && !qv_prev) begin
        observe(EvQuery, occ_query_x, occ_query_y, ex, ey);
        qx_exp = ex;
        qy_exp = ey;
      end else if (occ_query_valid) begin
        check("query_x_stable", occ_query_x, qx_exp);
        check("query_y_stable", occ_query_y, qy_exp);
      end
      if (crashed && !cr_prev) begin
        observe(EvCrash, pos_x, pos_y, ex, ey);
        fx = ex;
        fy = ey;
      end else if (crashed) begin
        check("crashed_pos_x_frozen", pos_x, fx);
        check("crashed_pos_y_frozen", pos_y, fy);
      end
      qv_prev = occ_query_valid;
      cr_prev = crashed;
    end
  end

  task automatic cyc_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit allow_start);
    start        = allow_start && ($urandom_range(0, 4) == 0);
    occ_valid    = ($urandom_range(0, 2) == 0);
    occ_hit      = 1'($urandom_range(0, 1));
    direction_in = 2'($urandom_range(0, 3));
  endtask

  task automatic settle_crashed();
    repeat (2) begin
      noise(1'b0);
      cyc_tick();
    end
  endtask

  task automatic begin_round();
    noise(1'b0);
    start     = 1'b1;
    occ_valid = 1'b0;
    push(EvSpawn, SX, SY, cyc + 1);
    foreach (occ[i, j]) occ[i][j] = 1'b0;
    occ[SX][SY] = 1'b1;
    px      = SX;
    py      = SY;
    n_steps = 0;
    cyc_tick();
    start = 1'b0;
    check("running_after_start", running, 1);
    ts = cyc;
  endtask

  // One game tick from the first WAIT_TICK cycle; ends set when the round crashed.
  task automatic do_step(input int d, input bit obs, output bit ended);
    int t_term, nx, ny, lat;
    bit wall, hit;
    t_term = ts + TD - 1;
    while (cyc < t_term) begin
      noise(1'b1);
      cyc_tick();
    end
    noise(1'b1);
    direction_in = 2'(d);
    nx = px;
    ny = py;
    case (d)
      0:       begin wall = (py == 0);      ny = py - 1; end
      1:       begin wall = (px == GW - 1); nx = px + 1; end
      2:       begin wall = (py == GH - 1); ny = py + 1; end
      default: begin wall = (px == 0);      nx = px - 1; end
    endcase
    if (wall) begin
      push(EvCrash, px, py, t_term + 1);
      cyc_tick();
      settle_crashed();
      ended = 1'b1;
    end else begin
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 1);
      hit = occ[nx][ny] || (obs && $urandom_range(0, 11) == 0) || (n_steps >= 40);
      push(EvQuery, nx, ny, t_term + 1);
      cyc_tick();
      repeat (lat) begin
        noise(1'b1);
        occ_valid = 1'b0;
        cyc_tick();
      end
      noise(1'b1);
      occ_valid = 1'b1;
      occ_hit   = hit;
      if (hit) begin
        push(EvCrash, px, py, t_term + 2 + lat);
        cyc_tick();
        settle_crashed();
        ended = 1'b1;
      end else begin
        push(EvMove, nx, ny, t_term + 2 + lat);
        px = nx;
        py = ny;
        occ[px][py] = 1'b1;
        n_steps++;
        cyc_tick();
        noise(1'b1);
        cyc_tick();
        ts    = cyc;
        ended = 1'b0;
      end
    end
  endtask

  task automatic random_round();
    bit ended;
    int d;
    begin_round();
    d     = 1;
    ended = 1'b0;
    while (!ended) begin
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 3);
      do_step(d, 1'b1, ended);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pos_x"}, pos_x, SX);
    check({tag, "_pos_y"}, pos_y, SY);
    check({tag, "_crashed"}, crashed, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_query_valid"}, occ_query_valid, 0);
    check({tag, "_trail_we"}, trail_we, 0);
    check({tag, "_step"}, step, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit ended;
    int fixed_dirs[4];
    int t_term;
    fixed_dirs   = '{3, 0, 1, 2};
    resetn       = 1'b0;
    start        = 1'b0;
    occ_valid    = 1'b0;
    occ_hit      = 1'b0;
    direction_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    resetn = 1'b1;
    repeat (3) begin
      noise(1'b0);
      cyc_tick();
    end
    check_idle("idle_ignores_occ");

    // Straight runs into each wall
    foreach (fixed_dirs[k]) begin
      begin_round();
      ended = 1'b0;
      while (!ended) do_step(fixed_dirs[k], 1'b0, ended);
    end

    repeat (30) random_round();

    // Reset while a query is outstanding, after one committed move
    begin_round();
    do_step(1, 1'b0, ended);
    t_term = ts + TD - 1;
    while (cyc < t_term) begin
      noise(1'b1);
      occ_valid = 1'b0;
      cyc_tick();
    end
    noise(1'b0);
    occ_valid    = 1'b0;
    direction_in = 2'b01;
    push(EvQuery, px + 1, py, t_term + 1);
    cyc_tick();
    repeat (2) begin
      start     = 1'b0;
      occ_valid = 1'b0;
      cyc_tick();
    end
    #2;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check_idle("reset_mid_query");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc_tick();
    mon_en = 1'b1;
    check_idle("after_reset_release");

    random_round();
    repeat (5) begin
      noise(1'b0);
      cyc_tick();
    end
    check("expected_events_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_mover.md
# player_mover

Downstream consumer of the player direction register in the TRON datapath. On every game tick it latches the filtered direction, computes the player's next grid cell, and checks that cell against the arena boundary and the trail-occupancy memory through a query handshake. It then either commits the move or declares a crash. It publishes the current head position and a per-step write strobe, which the trail memory and the VGA draw logic consume.

## Interface
Parameters:
- GRID_W, 160, arena width in cells
- GRID_H, 120, arena height in cells
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- TICK_DIV, 2500000, clock cycles per game tick (20 Hz at 50 MHz)
- START_X, 40, spawn x
- START_Y, 60, spawn y

Ports:
- CLOCK_50  in  1  system clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins or restarts a round
- direction_in  in  2  direction from the register: 00 up, 01 right, 10 down, 11 left
- occ_query_valid  out  1  occupancy query request
- occ_query_x  out  X_W  queried cell x
- occ_query_y  out  Y_W  queried cell y
- occ_valid  in  1  occupancy response valid
- occ_hit  in  1  queried cell is occupied; sampled only when occ_valid is high
- pos_x  out  X_W  current head x
- pos_y  out  Y_W  current head y
- trail_we  out  1  one-cycle strobe: write (pos_x,pos_y) into the trail
- step  out  1  one-cycle pulse per committed move
- crashed  out  1  high while in CRASHED
- running  out  1  high in WAIT_TICK, QUERY and MOVE

## Operation
- States: IDLE, WAIT_TICK, QUERY, MOVE, CRASHED.
- IDLE:
  - pos = (START_X, START_Y).
  - On start: go to WAIT_TICK, clear the tick counter, and pulse trail_we with the spawn cell.
- WAIT_TICK:
  - tick_cnt increments each cycle.
  - When tick_cnt == TICK_DIV-1:
    - latch direction_in into dir_q.
    - compute (nx, ny) from pos and dir_q: up y-1, right x+1, down y+1, left x-1.
  - Boundary check, done before any subtraction or increment is applied:
    - crash if up with y==0, left with x==0, right with x==GRID_W-1, or down with y==GRID_H-1.
    - On crash, go to CRASHED. Coordinates never wrap.
  - Otherwise, load nx/ny into the query registers and go to QUERY.
- QUERY:
  - occ_query_valid is held high, with x/y stable, until occ_valid is seen.
  - On occ_valid: if occ_hit, go to CRASHED; otherwise go to MOVE.
  - An occ_valid that arrives outside QUERY is ignored.
- MOVE (exactly one cycle):
  - pos <= (nx, ny).
  - trail_we = 1 and step = 1; trail_we addresses the new pos.
  - Go to WAIT_TICK with tick_cnt = 0.
- CRASHED:
  - pos frozen, crashed = 1.
  - start reloads the spawn position, pulses trail_we and goes to WAIT_TICK.
- start in WAIT_TICK, QUERY or MOVE is ignored. A round ends only by crash or reset.
- Direction changes between ticks are not observed; only the value present at the terminal tick cycle counts.

## Timing
- Reset (async assert, sync release) puts the block in IDLE with:
  - pos = (START_X, START_Y), tick_cnt = 0, dir_q = 01.
  - all strobes 0, occ_query_valid 0, crashed 0, running 0.
- Reset mid-QUERY drops occ_query_valid immediately, with no handshake completion.
- Tick terminal cycle T: state is QUERY at T+1 and occ_query_valid is registered high at T+1.
- If occ_valid is high at T+1+L (L ≥ 0), MOVE occurs at T+2+L. pos updates and trail_we/step are high during that cycle.
- Step period = TICK_DIV + 2 + L cycles.
- A boundary crash makes crashed high at T+1, with no query issued.
- An occupancy crash makes crashed high at T+2+L.
- trail_we on start is high in the cycle after start is sampled.
- All outputs are registered except trail_we and step, which are decoded from state == MOVE, or from the one-cycle spawn-write flag.

## Test plan
- Setup: TICK_DIV=4, GRID 8x8, spawn (2,2).
- Basic move: start, direction 01, occ_valid tied high with occ_hit=0 → pos (3,2) after 6 cycles, then (4,2) 6 cycles later; step pulses once per move; trail_we on spawn and on every step.
- Wall: spawn (2,2), direction 11 held → pos steps (1,2), (0,2); next tick gives crashed=1 with no occ_query_valid and pos stays (0,2). Repeat for right at x=7, up at y=0, down at y=7.
- Query handshake: delay occ_valid by 5 cycles → occ_query_valid and query x/y stay stable for all 5 cycles; the move commits the cycle after occ_valid.
- Occupancy crash: occ_hit=1 at the first response → crashed=1, pos remains (2,2), step never pulses.
- Direction sampling: toggle direction_in between ticks, settling on 10 at the terminal cycle → the move is down to (2,3).
- Reset/restart:
  - resetn low mid-QUERY → IDLE values immediately, query drops.
  - start after a crash → pos back at (2,2), trail_we pulses, running=1.
